// File: rtl/sockit_spi_pkg.sv
// SPI master shared definitions.
// IO mode codes, queue control fields, deserializer states.
package sockit_spi_pkg;

  localparam logic [1:0] IOM_3WR  = 2'd0;
  localparam logic [1:0] IOM_SPI  = 2'd1;
  localparam logic [1:0] IOM_DUAL = 2'd2;
  localparam logic [1:0] IOM_QUAD = 2'd3;

  localparam int CTL_NEW   = 3;
  localparam int CTL_LST   = 2;
  localparam int CTL_IOM_H = 1;
  localparam int CTL_IOM_L = 0;

  typedef logic [0:0] des_st_t;

  localparam des_st_t ST_IDLE  = 1'b0;
  localparam des_st_t ST_SHIFT = 1'b1;

endpackage

// File: rtl/sockit_spi_des_lane.sv
// One IO line: MSB-first sample shifter.
// jst is the left-justified lane including the incoming sample.
module sockit_spi_des_lane
  import sockit_spi_pkg::*;
#(
  parameter int SDW = 8,
  parameter int SDL = $clog2(SDW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           din,
  input  logic [SDL-1:0] cnt,
  output logic [SDW-1:0] jst
);

  logic [SDW-1:0] shf_q;
  logic [SDW-1:0] shf_d;
  logic [SDW-1:0] shf_nxt;
  logic [SDL-1:0] sft;

  always_comb begin
    shf_nxt = {shf_q[SDW-2:0], din};
    sft     = SDL'(SDW-1) - cnt;
    jst     = shf_nxt << sft;
  end

  always_comb begin
    shf_d = shf_q;
    if (clr)
      shf_d = '0;
    else if (en)
      shf_d = shf_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shf_q <= '0;
    else
      shf_q <= shf_d;
  end

endmodule

// File: rtl/sockit_spi_des.sv
// SPI input deserializer: samples to per-line lanes,
// one queue packet per segment.
module sockit_spi_des
  import sockit_spi_pkg::*;
#(
  parameter int SDW = 8,
  parameter int SDL = $clog2(SDW),
  parameter int QCI = 4,
  parameter int QDW = 4*SDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           seg_vld,
  input  logic [QCI-1:0] seg_ctl,
  input  logic [SDL-1:0] seg_cnt,
  output logic           seg_rdy,
  input  logic           smp_vld,
  input  logic [3:0]     smp_dat,
  output logic           smp_rdy,
  output logic           que_vld,
  output logic [QCI-1:0] que_ctl,
  output logic [QDW-1:0] que_dat,
  input  logic           que_rdy
);

  des_st_t        st_q, st_d;
  logic [SDL-1:0] cnt_q, cnt_d;
  logic [SDL-1:0] lim_q, lim_d;
  logic [QCI-1:0] ctl_q, ctl_d;
  logic           vld_q, vld_d;
  logic [QCI-1:0] qct_q, qct_d;
  logic [QDW-1:0] qdt_q, qdt_d;

  logic           seg_xfr;
  logic           smp_xfr;
  logic           smp_lst;
  logic           stall;
  logic [3:0]     lane_en;
  logic [SDW-1:0] lane_jst [4];
  logic [QDW-1:0] pkt;

  always_comb begin
    seg_rdy = (st_q == ST_IDLE);
    smp_lst = (st_q == ST_SHIFT) && (cnt_q == lim_q);
    stall   = smp_lst & vld_q & ~que_rdy;
    smp_rdy = (st_q == ST_SHIFT) & ~stall;
    seg_xfr = seg_vld & seg_rdy;
    smp_xfr = smp_vld & smp_rdy;
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sockit_spi_des_lane #(
      .SDW (SDW),
      .SDL (SDL)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (seg_xfr),
      .en  (smp_xfr),
      .din (smp_dat[i]),
      .cnt (lim_q),
      .jst (lane_jst[i])
    );
  end

  always_comb begin
    lane_en = 4'b0000;
    unique case (ctl_q[CTL_IOM_H:CTL_IOM_L])
      IOM_3WR:  lane_en = 4'b0001;
      IOM_SPI:  lane_en = 4'b0010;
      IOM_DUAL: lane_en = 4'b0011;
      IOM_QUAD: lane_en = 4'b1111;
      default:  lane_en = 4'b0000;
    endcase
  end

  always_comb begin
    pkt = '0;
    for (int i = 0; i < 4; i++)
      if (lane_en[i])
        pkt[i*SDW +: SDW] = lane_jst[i];
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    lim_d = lim_q;
    ctl_d = ctl_q;
    unique case (1'b1)
      seg_xfr: begin
        st_d  = ST_SHIFT;
        cnt_d = '0;
        lim_d = seg_cnt;
        ctl_d = seg_ctl;
      end
      smp_xfr: begin
        cnt_d = cnt_q + SDL'(1);
        if (smp_lst)
          st_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // load wins over drain so a same-cycle swap leaves no bubble
  always_comb begin
    vld_d = vld_q;
    qct_d = qct_q;
    qdt_d = qdt_q;
    if (smp_xfr && smp_lst) begin
      vld_d = 1'b1;
      qct_d = ctl_q;
      qdt_d = pkt;
    end else if (que_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      lim_q <= '0;
      ctl_q <= '0;
      vld_q <= 1'b0;
      qct_q <= '0;
      qdt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      ctl_q <= ctl_d;
      vld_q <= vld_d;
      qct_q <= qct_d;
      qdt_q <= qdt_d;
    end
  end

  assign que_vld = vld_q;
  assign que_ctl = qct_q;
  assign que_dat = qdt_q;

endmodule

// File: tb/tb_sockit_spi_des.sv
// Bench for sockit_spi_des: scoreboarded packets,
// latency, backpressure, drain/load and reset checks.
module tb_sockit_spi_des;

  logic        clk;
  logic        rst;
  logic        seg_vld;
  logic [3:0]  seg_ctl;
  logic [2:0]  seg_cnt;
  logic        seg_rdy;
  logic        smp_vld;
  logic [3:0]  smp_dat;
  logic        smp_rdy;
  logic        que_vld;
  logic [3:0]  que_ctl;
  logic [31:0] que_dat;
  logic        que_rdy;

  int n_chk;
  int n_err;
  logic [35:0] sb [$];

  sockit_spi_des u_dut (
    .clk     (clk),
    .rst     (rst),
    .seg_vld (seg_vld),
    .seg_ctl (seg_ctl),
    .seg_cnt (seg_cnt),
    .seg_rdy (seg_rdy),
    .smp_vld (smp_vld),
    .smp_dat (smp_dat),
    .smp_rdy (smp_rdy),
    .que_vld (que_vld),
    .que_ctl (que_ctl),
    .que_dat (que_dat),
    .que_rdy (que_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] ctl,
                                        input int cnt,
                                        input logic [31:0] smps);
    logic [31:0] r;
    logic [1:0]  m;
    bit          keep;
    r = '0;
    m = ctl[1:0];
    for (int i = 0; i < 4; i++) begin
      keep = (m == 2'd3) || (m == 2'd2 && i < 2) ||
             (m == 2'd1 && i == 1) || (m == 2'd0 && i == 0);
      for (int k = 0; k <= cnt; k++)
        if (keep) r[i*8 + 7 - k] = smps[4*k + i];
    end
    return r;
  endfunction

  always begin
    @(negedge clk);
    #4;
    if (!rst && que_vld && que_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_empty_pop", 1, 0);
      end else begin
        logic [35:0] e;
        e = sb.pop_front();
        chk("pkt_ctl", que_ctl, e[35:32]);
        chk("pkt_dat", que_dat, e[31:0]);
      end
    end
  end

  task automatic send_seg(input logic [3:0] ctl, input logic [2:0] cnt);
    bit ok;
    int n;
    seg_vld = 1'b1;
    seg_ctl = ctl;
    seg_cnt = cnt;
    n = 0;
    do begin
      #4 ok = seg_rdy;
      @(negedge clk);
      n++;
    end while (!ok && n < 100);
    seg_vld = 1'b0;
    seg_ctl = $urandom;
    if (!ok) chk("seg_timeout", 0, 1);
  endtask

  task automatic send_smp(input logic [3:0] d);
    bit ok;
    int n;
    smp_vld = 1'b1;
    smp_dat = d;
    n = 0;
    do begin
      #4 ok = smp_rdy;
      @(negedge clk);
      n++;
    end while (!ok && n < 100);
    smp_vld = 1'b0;
    smp_dat = $urandom;
    if (!ok) chk("smp_timeout", 0, 1);
  endtask

  task automatic run_seg(input logic [3:0] ctl, input int cnt,
                         input logic [31:0] smps,
                         input logic [31:0] exp_dat,
                         input bit use_model, input bit rdy_last);
    logic [31:0] e;
    e = use_model ? model(ctl, cnt, smps) : exp_dat;
    sb.push_back({ctl, e});
    send_seg(ctl, 3'(cnt));
    if (que_rdy) chk("smp_rdy_lat", smp_rdy, 1);
    for (int k = 0; k <= cnt; k++) begin
      if (k == cnt && rdy_last) que_rdy = 1'b1;
      send_smp(smps[4*k +: 4]);
    end
    chk("vld_lat", que_vld, 1);
    chk("seg_rdy_lat", seg_rdy, 1);
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b1;
    seg_vld = 1'b0;
    seg_ctl = '0;
    seg_cnt = '0;
    smp_vld = 1'b0;
    smp_dat = '0;
    que_rdy = 1'b1;
    #1;
    chk("rst_seg_rdy", seg_rdy, 1);
    chk("rst_smp_rdy", smp_rdy, 0);
    chk("rst_que_vld", que_vld, 0);
    chk("rst_que_ctl", que_ctl, 0);
    chk("rst_que_dat", que_dat, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seg(4'b0101, 7, 32'h2020_0202, 32'h0000_A500, 0, 0);
    run_seg(4'b1011, 1, 32'h0000_000F, 32'h8080_8080, 0, 0);
    run_seg(4'b0000, 2, 32'h0000_0B5B, 32'h0000_00E0, 0, 0);
    drain_wait();

    for (int t = 0; t < 6; t++)
      run_seg(4'($urandom), $urandom_range(0, 7), $urandom, 0, 1, 0);
    drain_wait();

    que_rdy = 1'b0;
    run_seg(4'b1110, 3, 32'h0000_A5C3, 0, 1, 0);
    fork
      run_seg(4'b0010, 1, 32'h0000_00F3, 0, 1, 0);
      begin
        repeat (8) @(negedge clk);
        #4;
        chk("bp_smp_rdy", smp_rdy, 0);
        chk("bp_que_vld", que_vld, 1);
        @(negedge clk);
        que_rdy = 1'b1;
      end
    join
    drain_wait();

    que_rdy = 1'b0;
    run_seg(4'b0111, 0, 32'h0000_0005, 0, 1, 0);
    run_seg(4'b1001, 2, 32'h0000_0321, 0, 1, 1);
    chk("dl_que_vld", que_vld, 1);
    chk("dl_que_dat", que_dat, model(4'b1001, 2, 32'h0000_0321));
    drain_wait();

    send_seg(4'b0011, 3'd7);
    send_smp(4'hF);
    send_smp(4'hF);
    send_smp(4'hF);
    rst = 1'b1;
    #1;
    chk("ar_seg_rdy", seg_rdy, 1);
    chk("ar_smp_rdy", smp_rdy, 0);
    chk("ar_que_vld", que_vld, 0);
    chk("ar_que_dat", que_dat, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seg(4'b0011, 3, 32'h0000_1248, 0, 1, 0);
    drain_wait();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sockit_spi_des.md
# sockit_spi_des

Input-side deserializer of the SPI master. It collects SPI data-line samples delivered by the serial clock generator once per sampling edge, packs them per IO line into SDW-bit lanes, and emits one queue-protocol packet per segment. Its output is the queue protocol consumed directly by the repackager, which converts it to 32-bit command words. Segments are described by a small command stream from the cycle controller.

## Interface
- SDW, 8, serial data register width (samples per lane per packet)
- SDL, $clog2(SDW), width of sample counter
- QCI, 4, queue control width: [3] new, [2] lst, [1:0] iom
- QDW, 4*SDW, queue data width; lane i = que_dat[(i+1)*SDW-1 : i*SDW] carries IO line i
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- seg_vld  input  1  segment descriptor valid
- seg_ctl  input  QCI  segment control, passed to que_ctl unchanged
- seg_cnt  input  SDL  number of samples in segment minus 1 (0..SDW-1)
- seg_rdy  output  1  segment accepted
- smp_vld  input  1  sample valid (one sampling edge)
- smp_dat  input  4  sampled IO lines [3:0]
- smp_rdy  output  1  sample accepted; low stalls the serial clock generator
- que_vld  output  1  packet valid
- que_ctl  output  QCI  packet control
- que_dat  output  QDW  packet data
- que_rdy  input  1  packet accepted

## Operation
- Handshakes: transfer on vld & rdy at rising clk; source holds data stable while vld & ~rdy.
- FSM states: IDLE, SHIFT.
  - IDLE: seg_rdy=1, smp_rdy=0. On seg transfer latch seg_ctl, seg_cnt; clear sample counter; go SHIFT.
  - SHIFT: seg_rdy=0. Each sample transfer shifts every lane MSB-first: lane_i <= {lane_i[SDW-2:0], smp_dat[i]}; counter increments.
  - Sample transfer with counter == seg_cnt is the last: packet loaded into output register, go IDLE.
- Output register: one entry (que_vld/ctl/dat). smp_rdy = SHIFT & ~(last sample pending & que_vld & ~que_rdy). Non-last samples are never stalled.
- Packet formation: each lane left-justified: lane shifted left by SDW-1-seg_cnt, vacated LSBs zero. First sample lands in lane bit SDW-1.
- Lane masking by iom: 0 (3-wire) keep lane 0; 1 (SPI) keep lane 1; 2 (dual) keep lanes 1,0; 3 (quad) keep all. Unused lanes forced to 0.
- que_ctl = latched seg_ctl.
- Output register drain and load in the same cycle are allowed (que_rdy & que_vld & last sample): new packet replaces old, que_vld stays 1.
- smp_vld in IDLE is ignored (smp_rdy=0); smp_dat bits are don't-care when smp_vld=0.

## Timing
- Reset values: seg_rdy=1, smp_rdy=0, que_vld=0, que_ctl=0, que_dat=0; FSM IDLE, counter 0, lanes 0.
- Reset mid-segment or with a packet pending discards all state; no partial packet is emitted.
- seg transfer at cycle N -> smp_rdy=1 at N+1.
- Last sample transfer at cycle M -> que_vld=1 at M+1, seg_rdy=1 at M+1. Minimum segment-to-segment gap: one IDLE cycle.
- que_vld falls the cycle after que_rdy unless reloaded the same cycle.
- Throughput: one sample per clk; one packet per seg_cnt+2 clks when unstalled.
- seg_cnt=0: single-sample packet; value in lane bit SDW-1 only.

## Structure
- Shared package sockit_spi_pkg: iom encoding constants (3-wire=0, SPI=1, dual=2, quad=3), que_ctl field indices (NEW=3, LST=2, IOM=1:0), FSM state typedef.
- Sub-module sockit_spi_des_lane: one SDW-bit MSB-first shifter with left-justify output, instantiated 4x. Masking, FSM, counter and output register stay in the top.

## Test plan
- SPI mode, SDW=8: seg_ctl=4'b0101, seg_cnt=7, samples on line1 = 1,0,1,0,0,1,0,1 -> que_dat=32'h0000_A500, que_ctl=4'b0101, one cycle after last sample.
- Quad, seg_cnt=1, smp_dat=4'hF then 4'h0 -> each lane 8'h80, que_dat=32'h8080_8080.
- 3-wire partial: seg_cnt=2, line0 = 1,1,1, other lines toggling -> que_dat=32'h0000_00E0 (unused lanes zero).
- Backpressure: que_rdy=0 with packet pending; next segment reaches its last sample -> smp_rdy=0 until que_rdy pulse; then both packets arrive intact in order.
- Simultaneous drain/load: que_rdy=1 in the same cycle as the last sample -> que_vld stays 1 and que_dat takes the new value with no bubble.
- Async rst asserted mid-SHIFT after 3 samples -> outputs at reset values immediately; the next segment produces a packet with no residue from old samples.
